// File: rtl/br_pkg.sv
// Shared types and constants for the conditional branch unit.
package br_pkg;

  // Width of the condition index carried with a branch request.
  localparam int COND_W      = 4;
  // Fixed positions of the pseudo-conditions inside the flag word.
  localparam int FLAG_ALWAYS = 11;
  localparam int FLAG_NEVER  = 10;

  // Branch resolution FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EVAL  = 2'd2,
    ST_REDIR = 2'd3
  } br_state_e;

  // A condition index is meaningful only when it addresses a real flag bit.
  function automatic logic cond_legal(input logic [COND_W-1:0] cond, input int nflag);
    return (int'(cond) < nflag);
  endfunction

endpackage

// File: rtl/cond_branch_unit_sat_counter.sv
// Saturating up-counter: counts pulses on i_inc and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Increment on request unless already saturated; never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cond_branch_unit.sv
// Conditional branch resolver: waits for in-flight CMP results to land in the
// compare-flag register, selects and optionally inverts one condition bit, and
// raises a fetch redirect for taken branches. Keeps taken / not-taken counts.
module cond_branch_unit
  import br_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int NFLAG   = 12,
  parameter int CMP_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NFLAG-1:0]  i_comp_reg,
  input  logic              i_cmp_issue,
  input  logic              i_flush,
  input  logic              i_br_valid,
  output logic              o_br_ready,
  input  logic [3:0]        i_br_cond,
  input  logic              i_br_invert,
  input  logic [ADDR_W-1:0] i_br_target,
  output logic              o_redir_valid,
  input  logic              i_redir_ready,
  output logic [ADDR_W-1:0] o_redir_pc,
  output logic              o_res_valid,
  output logic              o_res_taken,
  output logic              o_illegal,
  output logic [CNT_W-1:0]  o_taken_cnt,
  output logic [CNT_W-1:0]  o_ntaken_cnt
);

  // Hazard counter sizing: must hold CMP_LAT.
  localparam int              PEND_W     = (CMP_LAT < 2) ? 1 : $clog2(CMP_LAT + 1);
  localparam logic [PEND_W-1:0] PEND_LOAD = PEND_W'(CMP_LAT);
  // Every 4-bit condition index addresses this padded flag space.
  localparam int              FLAG_SPACE = 1 << COND_W;

  br_state_e             r_state, w_state_nxt;
  logic [PEND_W-1:0]     r_pend;
  logic [COND_W-1:0]     r_cond;
  logic                  r_invert;
  logic [ADDR_W-1:0]     r_target;

  logic                  w_stable;
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_taken;
  logic                  w_eval_fire;
  logic [FLAG_SPACE-1:0] w_flags_ext;

  // Flags are only trustworthy once no CMP is in flight and none issues now.
  assign w_stable = (r_pend == '0) && !i_cmp_issue;

  // Track outstanding CMP latency; a new CMP restarts the window, flush or not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
    end else if (i_cmp_issue) begin
      r_pend <= PEND_LOAD;
    end else if (r_pend != '0) begin
      r_pend <= r_pend - 1'b1;
    end
  end

  // Pad the flag word to the full index space and force ALWAYS/NEVER so that
  // those encodings resolve the same regardless of the register contents.
  always_comb begin
    w_flags_ext              = '0;
    w_flags_ext[NFLAG-1:0]   = i_comp_reg;
    w_flags_ext[FLAG_ALWAYS] = 1'b1;
    w_flags_ext[FLAG_NEVER]  = 1'b0;
  end

  // Out-of-range conditions resolve not-taken, inversion notwithstanding.
  assign w_legal = cond_legal(r_cond, NFLAG);
  assign w_taken = w_legal & (w_flags_ext[r_cond] ^ r_invert);

  // Next-state logic; flush overrides everything and blocks acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_br_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = w_stable ? ST_EVAL : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_stable) w_state_nxt = ST_EVAL;
        end
        ST_EVAL: begin
          w_state_nxt = w_taken ? ST_REDIR : ST_IDLE;
        end
        ST_REDIR: begin
          if (i_redir_ready) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the request on acceptance; the target doubles as the redirect PC
  // and stays put until the next acceptance, which keeps o_redir_pc stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cond   <= '0;
      r_invert <= 1'b0;
      r_target <= '0;
    end else if (w_accept) begin
      r_cond   <= i_br_cond;
      r_invert <= i_br_invert;
      r_target <= i_br_target;
    end
  end

  // A flush arriving in EVAL abandons the branch: no pulse, no count.
  assign w_eval_fire   = (r_state == ST_EVAL) && !i_flush;

  assign o_br_ready    = (r_state == ST_IDLE);
  assign o_res_valid   = w_eval_fire;
  assign o_res_taken   = w_eval_fire & w_taken;
  assign o_illegal     = w_eval_fire & !w_legal;
  assign o_redir_valid = (r_state == ST_REDIR);
  assign o_redir_pc    = o_redir_valid ? r_target : '0;

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_eval_fire & w_taken),
    .o_cnt   (o_taken_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ntaken_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_eval_fire & !w_taken),
    .o_cnt   (o_ntaken_cnt)
  );

endmodule

// File: tb/tb_cond_branch_unit.sv
// Bench for cond_branch_unit: directed and randomized branches against a
// transaction-level model (flag stability window, outcome, counters).
module tb_cond_branch_unit;

  localparam int ADDR_W  = 16;
  localparam int NFLAG   = 12;
  localparam int CMP_LAT = 1;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NFLAG-1:0]  i_comp_reg = '0;
  logic              i_cmp_issue = 1'b0;
  logic              i_flush = 1'b0;
  logic              i_br_valid = 1'b0;
  logic [3:0]        i_br_cond = '0;
  logic              i_br_invert = 1'b0;
  logic [ADDR_W-1:0] i_br_target = '0;
  logic              i_redir_ready = 1'b0;
  logic              o_br_ready, o_redir_valid, o_res_valid, o_res_taken, o_illegal;
  logic [ADDR_W-1:0] o_redir_pc;
  logic [CNT_W-1:0]  o_taken_cnt, o_ntaken_cnt;

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;
  int last_cmp = -100;
  int m_tk = 0;
  int m_ntk = 0;

  cond_branch_unit #(.ADDR_W(ADDR_W), .NFLAG(NFLAG), .CMP_LAT(CMP_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .i_comp_reg(i_comp_reg), .i_cmp_issue(i_cmp_issue),
    .i_flush(i_flush), .i_br_valid(i_br_valid), .o_br_ready(o_br_ready),
    .i_br_cond(i_br_cond), .i_br_invert(i_br_invert), .i_br_target(i_br_target),
    .o_redir_valid(o_redir_valid), .i_redir_ready(i_redir_ready), .o_redir_pc(o_redir_pc),
    .o_res_valid(o_res_valid), .o_res_taken(o_res_taken), .o_illegal(o_illegal),
    .o_taken_cnt(o_taken_cnt), .o_ntaken_cnt(o_ntaken_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // End the current cycle; remember when CMPs were issued for the model.
  task automatic tick;
    if (i_cmp_issue) last_cmp = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs;
    i_br_valid = 1'b0; i_cmp_issue = 1'b0; i_flush = 1'b0; i_redir_ready = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic model_taken(input logic [3:0] c, input logic inv, input logic [11:0] f);
    if (int'(c) >= NFLAG) return 1'b0;
    if (c == 4'd11) return ~inv;
    if (c == 4'd10) return inv;
    return f[c] ^ inv;
  endfunction

  task automatic bump(input logic tk);
    if (tk) m_tk  = (m_tk  == CMAX) ? CMAX : m_tk + 1;
    else    m_ntk = (m_ntk == CMAX) ? CMAX : m_ntk + 1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_taken_cnt"},  32'(o_taken_cnt),  32'(m_tk));
    chk({tag, "_ntaken_cnt"}, 32'(o_ntaken_cnt), 32'(m_ntk));
  endtask

  // One branch. Flags f0 in the accept cycle, f1 afterwards; cmask bit k
  // issues a CMP k cycles after acceptance; rdly = fetch stall cycles.
  task automatic do_branch(input logic [3:0] c, input logic inv, input logic [15:0] tgt,
                           input logic [11:0] f0, input logic [11:0] f1,
                           input logic [3:0] cmask, input int rdly);
    int n, e, lc, t_idle, t_end;
    logic tk, ill, in_redir;
    n = cyc; lc = last_cmp; e = n + 1;
    // Evaluate one cycle after the first cycle with no CMP in its window.
    for (int t = n; t < n + 16; t++) begin
      if ((t - n) < 4 && cmask[t - n]) lc = t;
      if (t >= lc + CMP_LAT + 1) begin e = t + 1; break; end
    end
    tk  = model_taken(c, inv, f1);
    ill = (int'(c) >= NFLAG);
    t_idle = tk ? e + 2 + rdly : e + 1;
    t_end  = (t_idle > n + 3) ? t_idle : n + 3;
    i_br_valid = 1'b1; i_br_cond = c; i_br_invert = inv; i_br_target = tgt;
    i_comp_reg = f0; i_cmp_issue = cmask[0]; i_flush = 1'b0; i_redir_ready = 1'b0;
    #4;
    chk("accept_ready", 32'(o_br_ready), 32'd1);
    tick();
    for (int t = n + 1; t <= t_end; t++) begin
      i_br_valid = 1'b0;
      i_comp_reg = f1;
      i_cmp_issue = ((t - n) < 4) ? cmask[t - n] : 1'b0;
      i_redir_ready = tk && (t == e + 1 + rdly);
      #4;
      in_redir = tk && (t >= e + 1) && (t <= e + 1 + rdly);
      if (t == e + 1) bump(tk);
      chk("res_valid", 32'(o_res_valid), 32'(t == e));
      chk("res_taken", 32'(o_res_taken), 32'((t == e) && tk));
      chk("illegal",   32'(o_illegal),   32'((t == e) && ill));
      chk("redir_valid", 32'(o_redir_valid), 32'(in_redir));
      chk("redir_pc", 32'(o_redir_pc), in_redir ? {16'h0, tgt} : 32'h0);
      chk("br_ready", 32'(o_br_ready), 32'(t >= t_idle));
      if (t == t_idle) chk_cnt("branch");
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    // Reset values, asynchronously asserted from time 0.
    #2;
    chk("rst_br_ready", 32'(o_br_ready), 32'd1);
    chk("rst_redir_valid", 32'(o_redir_valid), 32'd0);
    chk("rst_redir_pc", 32'(o_redir_pc), 32'd0);
    chk("rst_res_valid", 32'(o_res_valid), 32'd0);
    chk("rst_illegal", 32'(o_illegal), 32'd0);
    chk_cnt("rst");
    @(posedge clk); #1;
    tick();
    reset_n = 1'b1;
    idle_cycles(2);

    // Flag 0 set, stable flags: resolve N+1, redirect N+2.
    do_branch(4'd0, 1'b0, 16'h1234, 12'h805, 12'h805, 4'b0000, 0);
    // CMP in the accept cycle forces WAIT; the new flags are evaluated.
    do_branch(4'd0, 1'b0, 16'h2000, 12'h800, 12'h801, 4'b0001, 0);
    // NEVER, inverted ALWAYS, illegal index.
    do_branch(4'd10, 1'b0, 16'h3000, 12'hFFF, 12'hFFF, 4'b0000, 0);
    do_branch(4'd11, 1'b1, 16'h3004, 12'hFFF, 12'hFFF, 4'b0000, 0);
    do_branch(4'd13, 1'b1, 16'h3008, 12'hFFF, 12'hFFF, 4'b0000, 0);
    // Fetch stalls the redirect for 5 cycles.
    do_branch(4'd2, 1'b1, 16'hBEEF, 12'h000, 12'h000, 4'b0000, 5);
    // CMP issued during EVAL must not disturb that evaluation.
    do_branch(4'd1, 1'b0, 16'h4444, 12'h002, 12'h002, 4'b0010, 1);

    // Flush during WAIT: back to IDLE, no resolution.
    idle_cycles(3);
    i_br_valid = 1'b1; i_br_cond = 4'd11; i_br_invert = 1'b0; i_br_target = 16'h5555;
    i_cmp_issue = 1'b1;
    tick();
    i_br_valid = 1'b0; i_cmp_issue = 1'b0; i_flush = 1'b1;
    #4;
    chk("flush_wait_busy", 32'(o_br_ready), 32'd0);
    chk("flush_wait_res", 32'(o_res_valid), 32'd0);
    tick();
    i_flush = 1'b0;
    #4;
    chk("flush_wait_idle", 32'(o_br_ready), 32'd1);
    chk("flush_wait_res2", 32'(o_res_valid), 32'd0);
    tick();
    #4;
    chk("flush_wait_res3", 32'(o_res_valid), 32'd0);
    chk_cnt("flush_wait");
    tick();

    // A request presented with flush in IDLE is dropped.
    idle_cycles(2);
    i_br_valid = 1'b1; i_br_cond = 4'd11; i_flush = 1'b1;
    tick();
    idle_inputs();
    #4;
    chk("flush_idle_ready", 32'(o_br_ready), 32'd1);
    chk("flush_idle_res", 32'(o_res_valid), 32'd0);
    tick();
    #4;
    chk("flush_idle_redir", 32'(o_redir_valid), 32'd0);
    tick();

    // Flush during REDIR drops the redirect.
    idle_cycles(2);
    i_br_valid = 1'b1; i_br_cond = 4'd11; i_br_invert = 1'b0; i_br_target = 16'h6666;
    tick();
    i_br_valid = 1'b0;
    #4;
    chk("flush_redir_eval", 32'(o_res_taken), 32'd1);
    tick();
    bump(1'b1);
    #4;
    chk("flush_redir_valid", 32'(o_redir_valid), 32'd1);
    chk("flush_redir_pc", 32'(o_redir_pc), 32'h6666);
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    #4;
    chk("flush_redir_drop", 32'(o_redir_valid), 32'd0);
    chk("flush_redir_idle", 32'(o_br_ready), 32'd1);
    chk("flush_redir_res", 32'(o_res_valid), 32'd0);
    chk_cnt("flush_redir");
    tick();

    // Randomized branches with random CMP traffic and fetch stalls.
    for (int k = 0; k < 30; k++) begin
      do_branch(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'($urandom),
                12'($urandom), 12'($urandom), 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)));
    end

    // Reset in REDIR clears everything immediately.
    idle_cycles(3);
    i_br_valid = 1'b1; i_br_cond = 4'd11; i_br_invert = 1'b0; i_br_target = 16'h7777;
    tick();
    i_br_valid = 1'b0;
    tick();
    #4;
    chk("rst_mid_redir_pre", 32'(o_redir_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    m_tk = 0; m_ntk = 0; last_cmp = -100;
    chk("rst_mid_redir_valid", 32'(o_redir_valid), 32'd0);
    chk("rst_mid_redir_pc", 32'(o_redir_pc), 32'd0);
    chk("rst_mid_ready", 32'(o_br_ready), 32'd1);
    chk_cnt("rst_mid");
    tick();
    reset_n = 1'b1;
    idle_cycles(2);

    // Saturation: 20 taken branches on a 4-bit counter.
    for (int k = 0; k < 20; k++) begin
      do_branch(4'd11, 1'b0, 16'(16'h8000 + k), 12'h000, 12'h000, 4'b0000, 0);
    end
    chk("sat_taken", 32'(o_taken_cnt), 32'hF);
    chk("sat_ntaken", 32'(o_ntaken_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
